// File: rtl/alu_cmd_queue.sv
// Request FIFO and single-outstanding issue controller in front of the alu.
// Results are captured into a valid/ready register; a watchdog abandons ops that never return.
module alu_cmd_queue #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_a,
  input  logic [DATA_W-1:0]        s_b,
  input  logic [1:0]               s_cmd,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [1:0]               alu_cmd,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_res_valid,
  input  logic                     alu_ready,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W-1:0]        m_result,
  output logic [1:0]               m_cmd,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_timeout
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] OP_NOP = 2'b00;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   mem_a [DEPTH];
  logic [DATA_W-1:0]   mem_b [DEPTH];
  logic [1:0]          mem_cmd [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count_next;
  logic [1:0]          op_cmd;
  logic [WD_W-1:0]     wd;
  logic                push;
  logic                issue;

  // NOP requests complete the handshake but are never stored
  assign push  = s_valid && s_ready && (s_cmd != OP_NOP);
  assign issue = (state == ST_IDLE) && (o_count != '0) && alu_ready &&
                 (!m_valid || m_ready);

  always_comb begin
    count_next = o_count;
    case ({push, issue})
      2'b10:   count_next = o_count + 1'b1;
      2'b01:   count_next = o_count - 1'b1;
      default: count_next = o_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= s_a;
      mem_b[wr_ptr]   <= s_b;
      mem_cmd[wr_ptr] <= s_cmd;
    end
  end

  // s_ready is registered so every output reads 0 while reset is held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
      s_ready <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (issue) rd_ptr <= rd_ptr + 1'b1;
      o_count <= count_next;
      s_ready <= (count_next != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= OP_NOP;
      op_cmd    <= OP_NOP;
      wd        <= '0;
      m_valid   <= 1'b0;
      m_result  <= '0;
      m_cmd     <= OP_NOP;
      o_timeout <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            alu_a   <= mem_a[rd_ptr];
            alu_b   <= mem_b[rd_ptr];
            alu_cmd <= mem_cmd[rd_ptr];
            op_cmd  <= mem_cmd[rd_ptr];
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_cmd <= OP_NOP;
          wd      <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // a result arriving on the last allowed cycle still wins over the watchdog
          if (alu_res_valid) begin
            m_result <= alu_result;
            m_cmd    <= op_cmd;
            m_valid  <= 1'b1;
            state    <= ST_IDLE;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            o_timeout <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: directed steps plus randomized streaming against a
// queue-based reference of expected results, with a small behavioural alu.
module tb_alu_cmd_queue;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  logic [1:0]  s_cmd = OP_NOP;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_cmd;
  logic [31:0] alu_result = '0;
  logic        alu_res_valid = 1'b0;
  logic        alu_ready = 1'b1;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_result;
  logic [1:0]  m_cmd;
  logic [2:0]  o_count;
  logic        o_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  cmd;
  } exp_t;
  exp_t exp_q[$];

  // behavioural alu knobs
  int alu_lat  = 1;
  bit alu_dead = 0;
  bit alu_rand = 0;
  int alu_cnt  = 0;
  logic [31:0] alu_pend = '0;

  alu_cmd_queue #(.DATA_W(32), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_cmd(s_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_res_valid(alu_res_valid), .alu_ready(alu_ready),
    .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_cmd(m_cmd),
    .o_count(o_count), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] c);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return '0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] cmd,
                      input bit expect_res);
    bit ok;
    ok = 0;
    s_valid = 1'b1; s_a = a; s_b = b; s_cmd = cmd;
    for (int i = 0; i < 100 && !ok; i++) begin
      ok = (s_ready === 1'b1);
      tick(1);
    end
    s_valid = 1'b0;
    chk("push_accept", 64'(ok), 64'd1);
    if (ok && expect_res && cmd != OP_NOP) exp_q.push_back('{alu_fn(a, b, cmd), cmd});
  endtask

  task automatic wait_drain(input bit rand_ready);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    m_ready = 1'b1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    tick(2);
  endtask

  // alu: sees a command after its issue edge, answers alu_lat cycles later
  always @(negedge clk) begin
    alu_res_valid = 1'b0;
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        alu_res_valid = 1'b1;
        alu_result = alu_pend;
      end
    end
    if (alu_cmd != OP_NOP && !alu_dead) begin
      alu_pend = alu_fn(alu_a, alu_b, alu_cmd);
      alu_cnt  = alu_rand ? int'($urandom_range(1, 4)) : alu_lat;
    end
  end

  // every consumed result must be the oldest outstanding expected one
  always @(negedge clk) begin
    if (reset === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", {30'd0, m_cmd, m_result}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_order", {30'd0, m_cmd, m_result}, {30'd0, e.cmd, e.res});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    // reset state
    tick(2);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_alu_cmd", 64'(alu_cmd), 64'(OP_NOP));
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_result", 64'(m_result), 64'd0);
    chk("rst_o_count", 64'(o_count), 64'd0);
    chk("rst_o_timeout", 64'(o_timeout), 64'd0);
    reset = 1'b1;
    tick(1);

    // single ADD, observe issue pulse and capture
    m_ready = 1'b0;
    push(32'd5, 32'd7, OP_ADD, 1);
    chk("t2_count", 64'(o_count), 64'd1);
    tick(1);
    chk("t2_issue_cmd", 64'(alu_cmd), 64'(OP_ADD));
    chk("t2_issue_ab", {alu_a, alu_b}, {32'd5, 32'd7});
    chk("t2_count_pop", 64'(o_count), 64'd0);
    tick(1);
    chk("t2_nop_after", 64'(alu_cmd), 64'(OP_NOP));
    tick(1);
    chk("t2_m_valid", 64'(m_valid), 64'd1);
    chk("t2_m_result", 64'(m_result), 64'd12);
    chk("t2_m_cmd", 64'(m_cmd), 64'(OP_ADD));
    m_ready = 1'b1;
    tick(1);
    chk("t2_m_cleared", 64'(m_valid), 64'd0);

    // fill while alu busy, fifth request refused
    alu_ready = 1'b0;
    push(32'd1, 32'd2, OP_ADD, 1);
    push(32'd9, 32'd4, OP_SUB, 1);
    push(32'hF0F0, 32'h0FF0, OP_AND, 1);
    push(32'd100, 32'd200, OP_ADD, 1);
    chk("t3_full_count", 64'(o_count), 64'd4);
    chk("t3_full_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b1; s_a = 32'd50; s_b = 32'd60; s_cmd = OP_SUB;
    tick(1);
    chk("t3_refused", 64'(o_count), 64'd4);
    s_valid = 1'b0;
    alu_ready = 1'b1;
    push(32'd50, 32'd60, OP_SUB, 1);
    wait_drain(0);

    // backpressure blocks the next issue
    m_ready = 1'b0;
    push(32'd100, 32'd23, OP_ADD, 1);
    push(32'd50, 32'd8, OP_SUB, 1);
    for (int i = 0; i < 50 && m_valid !== 1'b1; i++) tick(1);
    tick(4);
    chk("t4_held_valid", 64'(m_valid), 64'd1);
    chk("t4_held_result", 64'(m_result), 64'd123);
    chk("t4_no_issue", 64'(alu_cmd), 64'(OP_NOP));
    chk("t4_queued", 64'(o_count), 64'd1);
    m_ready = 1'b1;
    tick(1);
    chk("t4_same_edge_issue", 64'(alu_cmd), 64'(OP_SUB));
    chk("t4_issue_a", 64'(alu_a), 64'd50);
    chk("t4_valid_dropped", 64'(m_valid), 64'd0);
    wait_drain(0);

    // watchdog: dead alu, op dropped after 8 WAIT cycles, next op proceeds
    alu_dead = 1'b1;
    push(32'd3, 32'd3, OP_ADD, 0);
    push(32'd77, 32'd7, OP_SUB, 1);
    tick(8);
    chk("t5_before_limit", 64'(o_timeout), 64'd0);
    tick(1);
    chk("t5_timeout", 64'(o_timeout), 64'd1);
    chk("t5_no_result", 64'(m_valid), 64'd0);
    alu_dead = 1'b0;
    tick(1);
    chk("t5_next_issue", 64'(alu_cmd), 64'(OP_SUB));
    wait_drain(0);
    chk("t5_sticky", 64'(o_timeout), 64'd1);

    // reset mid-WAIT with three entries queued
    alu_lat = 6;
    push(32'd11, 32'd1, OP_ADD, 0);
    push(32'd12, 32'd1, OP_ADD, 0);
    push(32'd13, 32'd1, OP_ADD, 0);
    push(32'd14, 32'd1, OP_ADD, 0);
    chk("t1_queued", 64'(o_count), 64'd3);
    reset = 1'b0;
    #1;
    chk("t1_count", 64'(o_count), 64'd0);
    chk("t1_alu_cmd", 64'(alu_cmd), 64'(OP_NOP));
    chk("t1_alu_b", 64'(alu_b), 64'd0);
    chk("t1_timeout_clr", 64'(o_timeout), 64'd0);
    chk("t1_s_ready", 64'(s_ready), 64'd0);
    tick(1);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (m_valid !== 1'b0) seen = 1;
    end
    chk("t1_late_valid_ignored", 64'(seen), 64'd0);
    chk("t1_count_after", 64'(o_count), 64'd0);
    alu_lat = 1;

    // randomized stream of ten ops, pointers wrap twice
    alu_rand = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [1:0] c;
      c = 2'($urandom_range(1, 3));
      if (i == 3) push(32'hFFFF_FFFF, 32'd1, OP_ADD, 1);
      else        push($urandom, $urandom, c, 1);
      if (i == 5) push($urandom, $urandom, OP_NOP, 1);
    end
    wait_drain(1);
    chk("t6_empty", 64'(o_count), 64'd0);
    chk("t6_m_idle", 64'(m_valid), 64'd0);
    chk("t6_no_timeout", 64'(o_timeout), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
